// File: rtl/bram_rr_arbiter_pkg.sv
// Shared definitions for the two-port BRAM round-robin arbiter.
// Port identifiers are used both for grant priority and for read-response routing.
package bram_rr_arbiter_pkg;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    function automatic port_e other_port(input port_e p);
        return (p == PORT_A) ? PORT_B : PORT_A;
    endfunction

endpackage

// File: rtl/bram_rr_arbiter_rr_arb2.sv
// Two-input round-robin grant: ties go to the priority port, and any grant
// hands priority to the losing side. Grants are suppressed while reset is high.
module rr_arb2
    import bram_rr_arbiter_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_a_i,
    input  logic req_b_i,
    output logic gnt_a_o,
    output logic gnt_b_o
);

    port_e prio_q, prio_d;
    port_e winner;
    logic  any_gnt;

    always_comb begin
        gnt_a_o = 1'b0;
        gnt_b_o = 1'b0;
        winner  = PORT_A;
        any_gnt = 1'b0;
        prio_d  = prio_q;

        if (!rst_i) begin
            if (req_a_i && (!req_b_i || prio_q == PORT_A)) begin
                winner  = PORT_A;
                any_gnt = 1'b1;
            end else if (req_b_i) begin
                winner  = PORT_B;
                any_gnt = 1'b1;
            end
        end

        if (any_gnt) begin
            gnt_a_o = (winner == PORT_A);
            gnt_b_o = (winner == PORT_B);
            prio_d  = other_port(winner);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prio_q <= PORT_A;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/bram_rr_arbiter.sv
// Shares one single-port BRAM between requester A and requester B with round-robin
// grants, tagged read tracking through the BRAM latency, and per-port response registers.
module bram_rr_arbiter
    import bram_rr_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 1
) (
    input  logic                  axi_clock,
    input  logic                  rst,

    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic                  a_req_we,
    input  logic [ADDR_WIDTH-1:0] a_req_addr,
    input  logic [DATA_WIDTH-1:0] a_req_din,
    output logic                  a_rsp_valid,
    input  logic                  a_rsp_ready,
    output logic [DATA_WIDTH-1:0] a_rsp_data,

    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic                  b_req_we,
    input  logic [ADDR_WIDTH-1:0] b_req_addr,
    input  logic [DATA_WIDTH-1:0] b_req_din,
    output logic                  b_rsp_valid,
    input  logic                  b_rsp_ready,
    output logic [DATA_WIDTH-1:0] b_rsp_data,

    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    input  logic [DATA_WIDTH-1:0] bram_dout
);

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_lat_check
        $error("bram_rr_arbiter: READ_LATENCY must be 1 or 2, got %0d", READ_LATENCY);
    end

    logic a_elig, b_elig;
    logic a_gnt, b_gnt;
    logic a_rd_gnt, b_rd_gnt;
    logic a_rd_busy_q, a_rd_busy_d;
    logic b_rd_busy_q, b_rd_busy_d;

    logic [READ_LATENCY-1:0] tag_vld_q, tag_vld_d;
    port_e                   tag_port_q [READ_LATENCY];
    port_e                   tag_port_d [READ_LATENCY];

    logic                  a_rsp_cap, b_rsp_cap;
    logic                  a_rsp_valid_q, a_rsp_valid_d;
    logic                  b_rsp_valid_q, b_rsp_valid_d;
    logic [DATA_WIDTH-1:0] a_rsp_data_q, a_rsp_data_d;
    logic [DATA_WIDTH-1:0] b_rsp_data_q, b_rsp_data_d;

    // A port with a read still outstanding may only issue writes.
    assign a_elig = a_req_valid & (a_req_we | ~a_rd_busy_q);
    assign b_elig = b_req_valid & (b_req_we | ~b_rd_busy_q);

    rr_arb2 u_rr_arb2 (
        .clk_i   (axi_clock),
        .rst_i   (rst),
        .req_a_i (a_elig),
        .req_b_i (b_elig),
        .gnt_a_o (a_gnt),
        .gnt_b_o (b_gnt)
    );

    assign a_req_ready = a_gnt;
    assign b_req_ready = b_gnt;
    assign a_rd_gnt    = a_gnt & ~a_req_we;
    assign b_rd_gnt    = b_gnt & ~b_req_we;

    always_comb begin
        bram_en   = a_gnt | b_gnt;
        bram_we   = (a_gnt & a_req_we) | (b_gnt & b_req_we);
        bram_addr = b_gnt ? b_req_addr : a_req_addr;
        bram_din  = b_gnt ? b_req_din  : a_req_din;
    end

    // Read tag pipeline mirrors the BRAM latency so the last stage lines up with bram_dout.
    assign tag_vld_d[0]  = a_rd_gnt | b_rd_gnt;
    assign tag_port_d[0] = b_rd_gnt ? PORT_B : PORT_A;

    for (genvar g = 1; g < READ_LATENCY; g++) begin : g_stage
        assign tag_vld_d[g]  = tag_vld_q[g-1];
        assign tag_port_d[g] = tag_port_q[g-1];
    end

    always_ff @(posedge axi_clock or posedge rst) begin
        if (rst) begin
            tag_vld_q  <= '0;
            tag_port_q <= '{default: PORT_A};
        end else begin
            tag_vld_q  <= tag_vld_d;
            tag_port_q <= tag_port_d;
        end
    end

    assign a_rsp_cap = tag_vld_q[READ_LATENCY-1] & (tag_port_q[READ_LATENCY-1] == PORT_A);
    assign b_rsp_cap = tag_vld_q[READ_LATENCY-1] & (tag_port_q[READ_LATENCY-1] == PORT_B);

    always_comb begin
        a_rsp_valid_d = a_rsp_valid_q;
        a_rsp_data_d  = a_rsp_data_q;
        b_rsp_valid_d = b_rsp_valid_q;
        b_rsp_data_d  = b_rsp_data_q;

        if (a_rsp_cap) begin
            a_rsp_valid_d = 1'b1;
            a_rsp_data_d  = bram_dout;
        end else if (a_rsp_valid_q && a_rsp_ready) begin
            a_rsp_valid_d = 1'b0;
        end

        if (b_rsp_cap) begin
            b_rsp_valid_d = 1'b1;
            b_rsp_data_d  = bram_dout;
        end else if (b_rsp_valid_q && b_rsp_ready) begin
            b_rsp_valid_d = 1'b0;
        end

        // Busy is released by the response handshake, never by the grant cycle itself.
        a_rd_busy_d = (a_rd_busy_q & ~(a_rsp_valid_q & a_rsp_ready)) | a_rd_gnt;
        b_rd_busy_d = (b_rd_busy_q & ~(b_rsp_valid_q & b_rsp_ready)) | b_rd_gnt;
    end

    always_ff @(posedge axi_clock or posedge rst) begin
        if (rst) begin
            a_rsp_valid_q <= 1'b0;
            a_rsp_data_q  <= '0;
            b_rsp_valid_q <= 1'b0;
            b_rsp_data_q  <= '0;
            a_rd_busy_q   <= 1'b0;
            b_rd_busy_q   <= 1'b0;
        end else begin
            a_rsp_valid_q <= a_rsp_valid_d;
            a_rsp_data_q  <= a_rsp_data_d;
            b_rsp_valid_q <= b_rsp_valid_d;
            b_rsp_data_q  <= b_rsp_data_d;
            a_rd_busy_q   <= a_rd_busy_d;
            b_rd_busy_q   <= b_rd_busy_d;
        end
    end

    assign a_rsp_valid = a_rsp_valid_q;
    assign a_rsp_data  = a_rsp_data_q;
    assign b_rsp_valid = b_rsp_valid_q;
    assign b_rsp_data  = b_rsp_data_q;

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// Bench for bram_rr_arbiter: two instances (READ_LATENCY 1 and 2) share directed stimulus;
// a transaction-level model checks every cycle, plus hand-computed literal expectations.
module tb_bram_rr_arbiter;

    localparam int DW = 32;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Shared stimulus, index 0 = port A, 1 = port B.
    logic          req_v    [2];
    logic          req_we   [2];
    logic [AW-1:0] req_addr [2];
    logic [DW-1:0] req_din  [2];
    logic          rsp_rdy  [2];

    // Per-instance outputs, first index = instance (0: latency 1, 1: latency 2).
    logic          o_rdy  [2][2];
    logic          o_rv   [2][2];
    logic [DW-1:0] o_rd   [2][2];
    logic          o_en   [2];
    logic          o_we   [2];
    logic [AW-1:0] o_addr [2];
    logic [DW-1:0] o_din  [2];
    logic [DW-1:0] dout   [2];

    int errors = 0;
    int checks = 0;

    bram_rr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1)) u_dut_l1 (
        .axi_clock(clk), .rst(rst),
        .a_req_valid(req_v[0]), .a_req_ready(o_rdy[0][0]), .a_req_we(req_we[0]),
        .a_req_addr(req_addr[0]), .a_req_din(req_din[0]),
        .a_rsp_valid(o_rv[0][0]), .a_rsp_ready(rsp_rdy[0]), .a_rsp_data(o_rd[0][0]),
        .b_req_valid(req_v[1]), .b_req_ready(o_rdy[0][1]), .b_req_we(req_we[1]),
        .b_req_addr(req_addr[1]), .b_req_din(req_din[1]),
        .b_rsp_valid(o_rv[0][1]), .b_rsp_ready(rsp_rdy[1]), .b_rsp_data(o_rd[0][1]),
        .bram_en(o_en[0]), .bram_we(o_we[0]), .bram_addr(o_addr[0]), .bram_din(o_din[0]),
        .bram_dout(dout[0])
    );

    bram_rr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2)) u_dut_l2 (
        .axi_clock(clk), .rst(rst),
        .a_req_valid(req_v[0]), .a_req_ready(o_rdy[1][0]), .a_req_we(req_we[0]),
        .a_req_addr(req_addr[0]), .a_req_din(req_din[0]),
        .a_rsp_valid(o_rv[1][0]), .a_rsp_ready(rsp_rdy[0]), .a_rsp_data(o_rd[1][0]),
        .b_req_valid(req_v[1]), .b_req_ready(o_rdy[1][1]), .b_req_we(req_we[1]),
        .b_req_addr(req_addr[1]), .b_req_din(req_din[1]),
        .b_rsp_valid(o_rv[1][1]), .b_rsp_ready(rsp_rdy[1]), .b_rsp_data(o_rd[1][1]),
        .bram_en(o_en[1]), .bram_we(o_we[1]), .bram_addr(o_addr[1]), .bram_din(o_din[1]),
        .bram_dout(dout[1])
    );

    function automatic logic [DW-1:0] init_word(input int a);
        case (a)
            3:       return 32'h0000_0033;
            4:       return 32'h0000_0044;
            5:       return 32'hDEAD_BEEF;
            default: return '0;
        endcase
    endfunction

    task automatic chk(input string name, input int d, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (lat%0d) at %0t: got %h, expected %h", name, d + 1, $time, act, exp);
        end
    endtask

    // BRAM models: one per instance, latency 1 and 2.
    logic [DW-1:0] mem [2][1<<AW];
    logic [DW-1:0] r1  [2];
    logic [DW-1:0] r2  [2];

    always_comb begin
        for (int d = 0; d < 2; d++) dout[d] = (d == 0) ? r1[d] : r2[d];
    end

    initial begin
        for (int d = 0; d < 2; d++)
            for (int a = 0; a < (1 << AW); a++) mem[d][a] = init_word(a);
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                if (o_en[d]) begin
                    if (o_we[d]) mem[d][o_addr[d]] <= o_din[d];
                    else         r1[d] <= mem[d][o_addr[d]];
                end
                r2[d] <= r1[d];
            end
        end
    end

    // Transaction-level reference model, evaluated on each falling edge.
    typedef struct {
        int            d;
        int            p;
        logic [DW-1:0] data;
        int            due;
    } pend_t;

    pend_t         pq[$];
    int            m_prio [2];
    bit            m_busy [2][2];
    bit            m_rv   [2][2];
    logic [DW-1:0] m_rd   [2][2];
    logic [DW-1:0] ref_mem [2][1<<AW];
    int            cyc;

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < (1 << AW); a++) ref_mem[d][a] = init_word(a);
            m_prio[d] = 0;
            for (int p = 0; p < 2; p++) begin
                m_busy[d][p] = 0;
                m_rv[d][p]   = 0;
                m_rd[d][p]   = '0;
            end
        end
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            for (int d = 0; d < 2; d++) begin
                int    win;
                int    sel;
                bit    el [2];
                pend_t e;
                if (rst) begin
                    m_prio[d] = 0;
                    for (int p = 0; p < 2; p++) begin
                        m_busy[d][p] = 0;
                        m_rv[d][p]   = 0;
                        m_rd[d][p]   = '0;
                    end
                    for (int i = pq.size() - 1; i >= 0; i--) if (pq[i].d == d) pq.delete(i);
                end
                for (int p = 0; p < 2; p++)
                    el[p] = !rst && req_v[p] && (req_we[p] || !m_busy[d][p]);
                win = -1;
                if (el[0] && el[1]) win = m_prio[d];
                else if (el[0])     win = 0;
                else if (el[1])     win = 1;
                sel = (win == 1) ? 1 : 0;

                chk("a_req_ready", d, o_rdy[d][0], win == 0);
                chk("b_req_ready", d, o_rdy[d][1], win == 1);
                chk("bram_en", d, o_en[d], win >= 0);
                chk("bram_we", d, o_we[d], (win >= 0) ? req_we[sel] : 1'b0);
                chk("bram_addr", d, o_addr[d], req_addr[sel]);
                chk("bram_din", d, o_din[d], req_din[sel]);
                chk("a_rsp_valid", d, o_rv[d][0], m_rv[d][0]);
                chk("b_rsp_valid", d, o_rv[d][1], m_rv[d][1]);
                chk("a_rsp_data", d, o_rd[d][0], m_rd[d][0]);
                chk("b_rsp_data", d, o_rd[d][1], m_rd[d][1]);

                if (!rst) begin
                    for (int p = 0; p < 2; p++) begin
                        if (m_rv[d][p] && rsp_rdy[p]) begin
                            m_rv[d][p]   = 0;
                            m_busy[d][p] = 0;
                        end
                    end
                    if (win >= 0) begin
                        m_prio[d] = 1 - win;
                        if (req_we[win]) begin
                            ref_mem[d][req_addr[win]] = req_din[win];
                        end else begin
                            m_busy[d][win] = 1;
                            e.d    = d;
                            e.p    = win;
                            e.data = ref_mem[d][req_addr[win]];
                            e.due  = cyc + d + 2;  // grant cycle + latency + 1
                            pq.push_back(e);
                        end
                    end
                    for (int i = pq.size() - 1; i >= 0; i--) begin
                        if (pq[i].d == d && pq[i].due == cyc + 1) begin
                            m_rv[d][pq[i].p] = 1;
                            m_rd[d][pq[i].p] = pq[i].data;
                            pq.delete(i);
                        end
                    end
                end
            end
        end
    end

    // Directed stimulus with literal expectations.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        for (int p = 0; p < 2; p++) begin
            req_v[p]  = 1'b0;
            req_we[p] = 1'b0;
        end
    endtask

    task automatic drive(input int p, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] dat);
        req_v[p]    = 1'b1;
        req_we[p]   = we;
        req_addr[p] = a;
        req_din[p]  = dat;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        drive(0, 1'b1, 10'd9, 32'h9999_9999);
        drive(1, 1'b1, 10'd9, 32'h8888_8888);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("lit_rst_a_ready", d, o_rdy[d][0], 0);
            chk("lit_rst_b_ready", d, o_rdy[d][1], 0);
            chk("lit_rst_bram_en", d, o_en[d], 0);
            chk("lit_rst_bram_we", d, o_we[d], 0);
            chk("lit_rst_a_rsp_valid", d, o_rv[d][0], 0);
        end
        tick();
        idle();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        for (int p = 0; p < 2; p++) begin
            req_addr[p] = '0;
            req_din[p]  = '0;
            rsp_rdy[p]  = 1'b1;
        end
        repeat (3) tick();

        // A reads addr 5.
        do_reset();
        tick(); drive(0, 1'b0, 10'd5, '0); #1;
        for (int d = 0; d < 2; d++) begin
            chk("lit_rd_a_ready", d, o_rdy[d][0], 1);
            chk("lit_rd_bram_addr", d, o_addr[d], 5);
        end
        tick(); idle(); #1;
        chk("lit_rd_a_rsp_early", 0, o_rv[0][0], 0);
        tick(); #1;
        chk("lit_rd_a_rsp_valid", 0, o_rv[0][0], 1);
        chk("lit_rd_a_rsp_data", 0, o_rd[0][0], 32'hDEAD_BEEF);
        chk("lit_rd_b_rsp_valid", 0, o_rv[0][1], 0);
        chk("lit_rd_a_rsp_early", 1, o_rv[1][0], 0);
        tick(); #1;
        chk("lit_rd_a_rsp_valid", 1, o_rv[1][0], 1);
        chk("lit_rd_a_rsp_data", 1, o_rd[1][0], 32'hDEAD_BEEF);

        // Both ports write continuously: alternate A, B, A, ...
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick();
            drive(0, 1'b1, 10'd1, 32'h11);
            drive(1, 1'b1, 10'd2, 32'h22);
            #1;
            for (int d = 0; d < 2; d++) begin
                chk("lit_wr_a_ready", d, o_rdy[d][0], (i % 2) == 0);
                chk("lit_wr_b_ready", d, o_rdy[d][1], (i % 2) == 1);
                chk("lit_wr_bram_we", d, o_we[d], 1);
            end
        end
        tick(); idle();
        tick();
        for (int d = 0; d < 2; d++) begin
            chk("lit_wr_mem1", d, mem[d][1], 32'h11);
            chk("lit_wr_mem2", d, mem[d][2], 32'h22);
        end

        // A read blocked by a stalled response while B keeps writing.
        do_reset();
        rsp_rdy[0] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            drive(0, 1'b0, 10'd5, '0);
            drive(1, 1'b1, 10'd8, 32'h100 + i);
            if (i == 10) rsp_rdy[0] = 1'b1;
            #1;
            for (int d = 0; d < 2; d++) begin
                chk("lit_bp_a_ready", d, o_rdy[d][0], (i == 0) || (i == 11));
                chk("lit_bp_b_ready", d, o_rdy[d][1], (i >= 1) && (i <= 10));
            end
        end
        for (int d = 0; d < 2; d++) chk("lit_bp_a_rsp_held", d, o_rv[d][0], 0);
        tick(); idle();
        repeat (5) tick();

        // Simultaneous reads: A first, then B.
        do_reset();
        tick(); drive(0, 1'b0, 10'd3, '0); drive(1, 1'b0, 10'd4, '0); #1;
        chk("lit_rr_a_ready", 1, o_rdy[1][0], 1);
        chk("lit_rr_b_ready", 1, o_rdy[1][1], 0);
        tick(); req_v[0] = 1'b0; #1;
        chk("lit_rr_b_ready", 1, o_rdy[1][1], 1);
        tick(); idle(); #1;
        chk("lit_rr_a_rsp_data", 0, o_rd[0][0], 32'h33);
        tick(); #1;
        chk("lit_rr_b_rsp_data", 0, o_rd[0][1], 32'h44);
        chk("lit_rr_a_rsp_valid", 1, o_rv[1][0], 1);
        chk("lit_rr_a_rsp_data", 1, o_rd[1][0], 32'h33);
        tick(); #1;
        chk("lit_rr_b_rsp_valid", 1, o_rv[1][1], 1);
        chk("lit_rr_b_rsp_data", 1, o_rd[1][1], 32'h44);
        tick();

        // Reset during an in-flight read.
        do_reset();
        tick(); drive(0, 1'b0, 10'd5, '0); #1;
        chk("lit_mr_a_ready", 0, o_rdy[0][0], 1);
        tick(); idle(); rst = 1'b1;
        tick(); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            for (int d = 0; d < 2; d++) chk("lit_mr_no_rsp", d, o_rv[d][0], 0);
            tick();
        end
        drive(0, 1'b1, 10'd10, 32'h1); drive(1, 1'b1, 10'd11, 32'h2); #1;
        for (int d = 0; d < 2; d++) chk("lit_mr_prio_a", d, o_rdy[d][0], 1);
        tick(); idle(); drive(0, 1'b0, 10'd5, '0); #1;
        chk("lit_mr_rd_ready", 0, o_rdy[0][0], 1);
        tick(); idle();
        tick(); #1;
        chk("lit_mr_rd_data", 0, o_rd[0][0], 32'hDEAD_BEEF);
        tick(); #1;
        chk("lit_mr_rd_data", 1, o_rd[1][0], 32'hDEAD_BEEF);

        // B writes addr 7, A reads it back.
        do_reset();
        tick(); drive(1, 1'b1, 10'd7, 32'hA5A5_A5A5); #1;
        chk("lit_wr_b_ready", 0, o_rdy[0][1], 1);
        tick(); idle(); drive(0, 1'b0, 10'd7, '0);
        tick(); idle();
        tick(); #1;
        chk("lit_wrrd_a_data", 0, o_rd[0][0], 32'hA5A5_A5A5);
        tick(); #1;
        chk("lit_wrrd_a_data", 1, o_rd[1][0], 32'hA5A5_A5A5);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
